// File: rtl/imem_loader_if.sv
// Byte-stream, command and instruction-memory write bundle for imem_loader.
// The slave modport is the loader; the master modport is whoever drives it.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              abort;
  logic [ADDR_W:0]   len;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              cpu_rst_n;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, abort, len, in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, cpu_rst_n, busy, done, err
  );

  modport slave (
    input  start, abort, len, in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, cpu_rst_n, busy, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// Fills instruction memory from a little-endian byte stream and releases the CPU when done.
// Define LOADER_CHECKSUM_EN to require a trailing 32-bit word-sum checksum before release.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int WORDS  = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  imem_loader_if.slave bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(WORDS);

  logic [2:0]        state_reg;
  logic [1:0]        byte_cnt_reg;
  logic [ADDR_W-1:0] word_cnt_reg;
  logic [ADDR_W:0]   len_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [31:0]       wr_data_reg;
  logic              err_reg;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]       sum_reg;
`endif

  logic        byte_acc;
  logic        len_ok;
  logic        last_word;
  logic [31:0] byte_word;

  assign bus.in_ready  = (state_reg == S_LOAD) || (state_reg == S_CHECK);
  assign bus.wr_en     = (state_reg == S_WRITE);
  assign bus.busy      = (state_reg == S_LOAD) || (state_reg == S_WRITE) || (state_reg == S_CHECK);
  assign bus.done      = (state_reg == S_DONE);
  assign bus.cpu_rst_n = (state_reg == S_DONE);
  assign bus.wr_addr   = wr_addr_reg;
  assign bus.wr_data   = wr_data_reg;
  assign bus.err       = err_reg;

  assign byte_acc  = bus.in_ready && bus.in_valid;
  assign len_ok    = (bus.len != '0) && (bus.len <= MAX_LEN);
  assign last_word = ({1'b0, word_cnt_reg} == (len_reg - (ADDR_W+1)'(1)));

  // Each lane keeps its byte; the lane being filled this cycle is taken straight
  // from the stream so the complete word is available on the 4th handshake.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          lane_reg <= '0;
        else if (byte_acc && (byte_cnt_reg == 2'(gi)))
          lane_reg <= bus.in_data;
      end
      assign byte_word[8*gi +: 8] = (byte_cnt_reg == 2'(gi)) ? bus.in_data : lane_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      byte_cnt_reg <= '0;
      word_cnt_reg <= '0;
      len_reg      <= '0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
      err_reg      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_reg      <= '0;
`endif
    end else if (bus.abort && (state_reg != S_IDLE)) begin
      state_reg    <= S_IDLE;
      byte_cnt_reg <= '0;
      word_cnt_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          // abort in IDLE is a no-op but still suppresses a coincident start
          if (bus.start && !bus.abort) begin
            if (len_ok) begin
              state_reg    <= S_LOAD;
              len_reg      <= bus.len;
              err_reg      <= 1'b0;
              byte_cnt_reg <= '0;
              word_cnt_reg <= '0;
`ifdef LOADER_CHECKSUM_EN
              sum_reg      <= '0;
`endif
            end else begin
              state_reg <= S_IDLE;
              err_reg   <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (byte_acc) begin
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            if (byte_cnt_reg == 2'd3) begin
              state_reg   <= S_WRITE;
              wr_addr_reg <= word_cnt_reg;
              wr_data_reg <= byte_word;
            end
          end
        end
        S_WRITE: begin
`ifdef LOADER_CHECKSUM_EN
          sum_reg <= sum_reg + wr_data_reg;
`endif
          if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
            state_reg <= S_CHECK;
`else
            state_reg <= S_DONE;
`endif
          end else begin
            word_cnt_reg <= word_cnt_reg + ADDR_W'(1);
            state_reg    <= S_LOAD;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (byte_acc) begin
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            if (byte_cnt_reg == 2'd3) begin
              if (byte_word == sum_reg) begin
                state_reg <= S_DONE;
              end else begin
                state_reg <= S_IDLE;
                err_reg   <= 1'b1;
              end
            end
          end
        end
`endif
        default: state_reg <= S_IDLE;
      endcase
    end
  end
endmodule
